// File: rtl/reg_fwd_stage.sv
// Register-fetch / forwarding stage: 128x128 register table, three operand reads resolved against pipe taps and writeback.
// Latency: one cycle from sampled inputs to registered operands and decoded fields.
// Backpressure: stall holds every output register; flush overrides stall and issues a nop; table writes never stall.
module reg_fwd_stage #(
  parameter int FWD_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [10:0]              op_in,
  input  logic [2:0]               format_in,
  input  logic [6:0]               rt_addr_in,
  input  logic [17:0]              imm_in,
  input  logic                     reg_write_in,
  input  logic [6:0]               ra_addr,
  input  logic [6:0]               rb_addr,
  input  logic [6:0]               rc_addr,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [FWD_DEPTH*128-1:0] fwd_even_data,
  input  logic [FWD_DEPTH*7-1:0]   fwd_even_addr,
  input  logic [FWD_DEPTH-1:0]     fwd_even_valid,
  input  logic [FWD_DEPTH*128-1:0] fwd_odd_data,
  input  logic [FWD_DEPTH*7-1:0]   fwd_odd_addr,
  input  logic [FWD_DEPTH-1:0]     fwd_odd_valid,
  input  logic [127:0]             wb_even_data,
  input  logic [6:0]               wb_even_addr,
  input  logic                     wb_even_we,
  input  logic [127:0]             wb_odd_data,
  input  logic [6:0]               wb_odd_addr,
  input  logic                     wb_odd_we,
  output logic [10:0]              op,
  output logic [2:0]               format,
  output logic [6:0]               rt_addr,
  output logic [17:0]              imm,
  output logic                     reg_write,
  output logic [127:0]             ra,
  output logic [127:0]             rb,
  output logic [127:0]             rc
);

  localparam int NUM_REGS = 128;
  localparam int NUM_SRC  = 3;

  // Architected register file.
  logic [127:0] reg_table [NUM_REGS];

  // The three source operands handled uniformly by index (0=ra, 1=rb, 2=rc).
  logic [6:0]   src_addr [NUM_SRC];
  logic [127:0] src_val  [NUM_SRC];

  assign src_addr[0] = ra_addr;
  assign src_addr[1] = rb_addr;
  assign src_addr[2] = rc_addr;

  // An all-zero opcode in format 0 is the architectural nop.
  logic is_nop;
  assign is_nop = (format_in == 3'd0) && (op_in == 11'd0);

  // Table update: odd port first so that the even port wins a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_table[i] <= '0;
      end
    end else begin
      if (wb_odd_we) begin
        reg_table[wb_odd_addr] <= wb_odd_data;
      end
      if (wb_even_we) begin
        reg_table[wb_even_addr] <= wb_even_data;
      end
    end
  end

  // Operand resolution, applied from lowest to highest priority so the last hit wins:
  // table, wb_odd, wb_even, then taps from oldest to youngest with even beating odd at equal depth.
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      src_val[s] = reg_table[src_addr[s]];
      if (wb_odd_we && (wb_odd_addr == src_addr[s])) begin
        src_val[s] = wb_odd_data;
      end
      if (wb_even_we && (wb_even_addr == src_addr[s])) begin
        src_val[s] = wb_even_data;
      end
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (fwd_odd_valid[k] && (fwd_odd_addr[k*7 +: 7] == src_addr[s])) begin
          src_val[s] = fwd_odd_data[k*128 +: 128];
        end
        if (fwd_even_valid[k] && (fwd_even_addr[k*7 +: 7] == src_addr[s])) begin
          src_val[s] = fwd_even_data[k*128 +: 128];
        end
      end
    end
  end

  // Output register: flush (or a nop) loads zeros, stall holds, otherwise capture fields and operands.
  always_ff @(posedge clk) begin
    if (reset || flush || (!stall && is_nop)) begin
      op        <= '0;
      format    <= '0;
      rt_addr   <= '0;
      imm       <= '0;
      reg_write <= 1'b0;
      ra        <= '0;
      rb        <= '0;
      rc        <= '0;
    end else if (!stall) begin
      op        <= op_in;
      format    <= format_in;
      rt_addr   <= rt_addr_in;
      imm       <= imm_in;
      reg_write <= reg_write_in;
      ra        <= src_val[0];
      rb        <= src_val[1];
      rc        <= src_val[2];
    end
  end

endmodule

// File: tb/tb_reg_fwd_stage.sv
// Bench for reg_fwd_stage: directed vector table, hand sequences for stall/flush/reset, then random traffic.
// Latency: each stimulus cycle is checked one clock after it is applied.
// Backpressure: stall/flush/reset are driven directly, including random mixes.
module tb_reg_fwd_stage;

  localparam int D = 4;

  logic           clk;
  logic           reset;
  logic [10:0]    op_in;
  logic [2:0]     format_in;
  logic [6:0]     rt_addr_in;
  logic [17:0]    imm_in;
  logic           reg_write_in;
  logic [6:0]     ra_addr, rb_addr, rc_addr;
  logic           stall, flush;
  logic [D*128-1:0] fwd_even_data, fwd_odd_data;
  logic [D*7-1:0]   fwd_even_addr, fwd_odd_addr;
  logic [D-1:0]     fwd_even_valid, fwd_odd_valid;
  logic [127:0]   wb_even_data, wb_odd_data;
  logic [6:0]     wb_even_addr, wb_odd_addr;
  logic           wb_even_we, wb_odd_we;
  logic [10:0]    op;
  logic [2:0]     format;
  logic [6:0]     rt_addr;
  logic [17:0]    imm;
  logic           reg_write;
  logic [127:0]   ra, rb, rc;

  reg_fwd_stage #(.FWD_DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .op_in(op_in), .format_in(format_in), .rt_addr_in(rt_addr_in), .imm_in(imm_in),
    .reg_write_in(reg_write_in),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .rc_addr(rc_addr),
    .stall(stall), .flush(flush),
    .fwd_even_data(fwd_even_data), .fwd_even_addr(fwd_even_addr), .fwd_even_valid(fwd_even_valid),
    .fwd_odd_data(fwd_odd_data), .fwd_odd_addr(fwd_odd_addr), .fwd_odd_valid(fwd_odd_valid),
    .wb_even_data(wb_even_data), .wb_even_addr(wb_even_addr), .wb_even_we(wb_even_we),
    .wb_odd_data(wb_odd_data), .wb_odd_addr(wb_odd_addr), .wb_odd_we(wb_odd_we),
    .op(op), .format(format), .rt_addr(rt_addr), .imm(imm), .reg_write(reg_write),
    .ra(ra), .rb(rb), .rc(rc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: architectural register contents and expected output registers.
  typedef struct {
    logic [10:0]  op;
    logic [2:0]   fmt;
    logic [6:0]   rt;
    logic [17:0]  imm;
    logic         rw;
    logic [127:0] ra, rb, rc;
  } out_t;

  typedef struct {
    logic [6:0]   addr;
    logic [127:0] data;
  } cand_t;

  logic [127:0] m_tab [128];
  out_t         m_out;

  typedef struct {
    logic [10:0]  op;
    logic [2:0]   fmt;
    logic [6:0]   a_ra, a_rb, a_rc;
    logic         we_e;
    logic [6:0]   wa_e;
    logic [127:0] wd_e;
    logic         we_o;
    logic [6:0]   wa_o;
    logic [127:0] wd_o;
    int           ek;
    logic [6:0]   ea;
    logic [127:0] edat;
    logic         ev;
    int           ok;
    logic [6:0]   oa;
    logic [127:0] odat;
    logic         ov;
    logic [127:0] x_ra, x_rb, x_rc;
    logic         x_rw;
  } vec_t;

  vec_t vt [14];

  function automatic logic [127:0] rep(input logic [7:0] b);
    return {16{b}};
  endfunction

  function automatic vec_t v(input logic [10:0] o, input logic [2:0] f,
                             input logic [6:0] a0, input logic [6:0] a1, input logic [6:0] a2,
                             input logic [127:0] x0, input logic [127:0] x1, input logic [127:0] x2,
                             input logic xrw);
    vec_t r;
    r = '{op: o, fmt: f, a_ra: a0, a_rb: a1, a_rc: a2,
          we_e: 1'b0, wa_e: 7'd0, wd_e: '0, we_o: 1'b0, wa_o: 7'd0, wd_o: '0,
          ek: 0, ea: 7'd0, edat: '0, ev: 1'b0, ok: 0, oa: 7'd0, odat: '0, ov: 1'b0,
          x_ra: x0, x_rb: x1, x_rc: x2, x_rw: xrw};
    return r;
  endfunction

  // Architectural lookup: list all live producers youngest-first, take the first with a matching address.
  function automatic logic [127:0] m_resolve(input logic [6:0] a);
    cand_t q[$];
    for (int k = 0; k < D; k++) begin
      if (fwd_even_valid[k]) q.push_back('{fwd_even_addr[k*7 +: 7], fwd_even_data[k*128 +: 128]});
      if (fwd_odd_valid[k])  q.push_back('{fwd_odd_addr[k*7 +: 7],  fwd_odd_data[k*128 +: 128]});
    end
    if (wb_even_we) q.push_back('{wb_even_addr, wb_even_data});
    if (wb_odd_we)  q.push_back('{wb_odd_addr,  wb_odd_data});
    foreach (q[i]) begin
      if (q[i].addr == a) return q[i].data;
    end
    return m_tab[a];
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    op_in = '0; format_in = '0; rt_addr_in = '0; imm_in = '0; reg_write_in = 1'b0;
    ra_addr = '0; rb_addr = '0; rc_addr = '0;
    fwd_even_data = '0; fwd_even_addr = '0; fwd_even_valid = '0;
    fwd_odd_data = '0; fwd_odd_addr = '0; fwd_odd_valid = '0;
    wb_even_data = '0; wb_even_addr = '0; wb_even_we = 1'b0;
    wb_odd_data = '0; wb_odd_addr = '0; wb_odd_we = 1'b0;
  endtask

  // Advance the model over the current inputs, clock the DUT, then compare every output.
  task automatic cycle();
    out_t nxt;
    nxt = m_out;
    if (reset) begin
      nxt = '{default: '0};
      for (int i = 0; i < 128; i++) m_tab[i] = '0;
    end else begin
      if (flush || (!stall && format_in == 3'd0 && op_in == 11'd0)) begin
        nxt = '{default: '0};
      end else if (!stall) begin
        nxt.op = op_in; nxt.fmt = format_in; nxt.rt = rt_addr_in;
        nxt.imm = imm_in; nxt.rw = reg_write_in;
        nxt.ra = m_resolve(ra_addr);
        nxt.rb = m_resolve(rb_addr);
        nxt.rc = m_resolve(rc_addr);
      end
      if (wb_odd_we)  m_tab[wb_odd_addr]  = wb_odd_data;
      if (wb_even_we) m_tab[wb_even_addr] = wb_even_data;
    end
    m_out = nxt;
    @(posedge clk);
    #1;
    chk("model_fields", {op, format, rt_addr, imm, reg_write},
        {m_out.op, m_out.fmt, m_out.rt, m_out.imm, m_out.rw});
    chk("model_ra", ra, m_out.ra);
    chk("model_rb", rb, m_out.rb);
    chk("model_rc", rc, m_out.rc);
  endtask

  initial begin
    m_out = '{default: '0};
    for (int i = 0; i < 128; i++) m_tab[i] = '0;

    // Directed vectors.
    vt[0]  = v(11'd0, 3'd0, 7'd0, 7'd5, 7'd127, '0, '0, '0, 1'b0);
    vt[1]  = v(11'd1, 3'd1, 7'd0, 7'd5, 7'd127, '0, '0, '0, 1'b1);
    vt[2]  = v(11'd1, 3'd1, 7'd10, 7'd0, 7'd0, rep(8'hAA), '0, '0, 1'b1);
    vt[2].we_e = 1'b1; vt[2].wa_e = 7'd10; vt[2].wd_e = rep(8'hAA);
    vt[3]  = v(11'd1, 3'd1, 7'd10, 7'd10, 7'd0, rep(8'hAA), rep(8'hAA), '0, 1'b1);
    vt[4]  = v(11'd1, 3'd1, 7'd7, 7'd0, 7'd0, rep(8'h22), '0, '0, 1'b1);
    vt[4].ek = 2; vt[4].ea = 7'd7; vt[4].edat = rep(8'h11); vt[4].ev = 1'b1;
    vt[4].ok = 0; vt[4].oa = 7'd7; vt[4].odat = rep(8'h22); vt[4].ov = 1'b1;
    vt[4].we_e = 1'b1; vt[4].wa_e = 7'd7; vt[4].wd_e = rep(8'h33);
    vt[5] = vt[4];
    vt[5].ov = 1'b0; vt[5].x_ra = rep(8'h11);
    vt[6]  = v(11'd1, 3'd1, 7'd7, 7'd0, 7'd0, rep(8'h33), '0, '0, 1'b1);
    vt[7]  = v(11'd1, 3'd1, 7'd3, 7'd0, 7'd0, rep(8'h01), '0, '0, 1'b1);
    vt[7].we_e = 1'b1; vt[7].wa_e = 7'd3; vt[7].wd_e = rep(8'h01);
    vt[7].we_o = 1'b1; vt[7].wa_o = 7'd3; vt[7].wd_o = rep(8'h02);
    vt[8]  = v(11'd1, 3'd1, 7'd3, 7'd3, 7'd3, rep(8'h01), rep(8'h01), rep(8'h01), 1'b1);
    vt[9]  = v(11'd1, 3'd1, 7'd3, 7'd0, 7'd0, rep(8'h01), '0, '0, 1'b1);
    vt[9].ek = 0; vt[9].ea = 7'd3; vt[9].edat = rep(8'hFF); vt[9].ev = 1'b0;
    vt[9].ok = 1; vt[9].oa = 7'd3; vt[9].odat = rep(8'hEE); vt[9].ov = 1'b0;
    vt[10] = v(11'd1, 3'd1, 7'd20, 7'd0, 7'd0, rep(8'h5A), '0, '0, 1'b1);
    vt[10].we_o = 1'b1; vt[10].wa_o = 7'd20; vt[10].wd_o = rep(8'h5A);
    vt[11] = v(11'd1, 3'd1, 7'd0, 7'd20, 7'd0, '0, rep(8'h5A), '0, 1'b1);
    vt[12] = v(11'd1, 3'd1, 7'd9, 7'd0, 7'd0, rep(8'h55), '0, '0, 1'b1);
    vt[12].ek = 1; vt[12].ea = 7'd9; vt[12].edat = rep(8'h44); vt[12].ev = 1'b1;
    vt[12].ok = 0; vt[12].oa = 7'd9; vt[12].odat = rep(8'h55); vt[12].ov = 1'b1;
    vt[13] = vt[12];
    vt[13].ek = 0; vt[13].edat = rep(8'h66); vt[13].x_ra = rep(8'h66);

    // Reset cycle.
    clear_inputs();
    reset = 1'b1;
    cycle();
    chk("reset_ra", ra, '0);
    chk("reset_op", op, '0);

    for (int i = 0; i < 14; i++) begin
      clear_inputs();
      op_in = vt[i].op; format_in = vt[i].fmt; rt_addr_in = 7'd1; imm_in = 18'h3;
      reg_write_in = 1'b1;
      ra_addr = vt[i].a_ra; rb_addr = vt[i].a_rb; rc_addr = vt[i].a_rc;
      wb_even_we = vt[i].we_e; wb_even_addr = vt[i].wa_e; wb_even_data = vt[i].wd_e;
      wb_odd_we = vt[i].we_o; wb_odd_addr = vt[i].wa_o; wb_odd_data = vt[i].wd_o;
      fwd_even_addr[vt[i].ek*7 +: 7] = vt[i].ea;
      fwd_even_data[vt[i].ek*128 +: 128] = vt[i].edat;
      fwd_even_valid[vt[i].ek] = vt[i].ev;
      fwd_odd_addr[vt[i].ok*7 +: 7] = vt[i].oa;
      fwd_odd_data[vt[i].ok*128 +: 128] = vt[i].odat;
      fwd_odd_valid[vt[i].ok] = vt[i].ov;
      cycle();
      chk($sformatf("vec%0d_ra", i), ra, vt[i].x_ra);
      chk($sformatf("vec%0d_rb", i), rb, vt[i].x_rb);
      chk($sformatf("vec%0d_rc", i), rc, vt[i].x_rc);
      chk($sformatf("vec%0d_rw", i), reg_write, vt[i].x_rw);
      chk($sformatf("vec%0d_op", i), op, vt[i].op);
    end

    // cntb issue, then two stalled cycles with a table write in the first.
    clear_inputs();
    op_in = 11'b01010110100; format_in = 3'd0; rt_addr_in = 7'd5; reg_write_in = 1'b1;
    ra_addr = 7'd10;
    cycle();
    chk("cntb_op", op, 11'b01010110100);
    chk("cntb_ra", ra, rep(8'hAA));
    clear_inputs();
    stall = 1'b1; op_in = 11'd1; format_in = 3'd1; ra_addr = 7'd3;
    wb_even_we = 1'b1; wb_even_addr = 7'd30; wb_even_data = rep(8'h77);
    cycle();
    chk("stall1_op", op, 11'b01010110100);
    chk("stall1_ra", ra, rep(8'hAA));
    wb_even_we = 1'b0;
    cycle();
    chk("stall2_op", op, 11'b01010110100);
    chk("stall2_rw", reg_write, 1'b1);
    flush = 1'b1;
    cycle();
    chk("flush_op", op, '0);
    chk("flush_rw", reg_write, 1'b0);
    chk("flush_ra", ra, '0);
    clear_inputs();
    op_in = 11'd1; format_in = 3'd1; reg_write_in = 1'b1; ra_addr = 7'd30;
    cycle();
    chk("stall_write_ra", ra, rep(8'h77));

    // Reset while a write is pending: write dropped, table cleared.
    clear_inputs();
    op_in = 11'd1; format_in = 3'd1; reg_write_in = 1'b1; ra_addr = 7'd10;
    wb_even_we = 1'b1; wb_even_addr = 7'd40; wb_even_data = rep(8'hCC);
    reset = 1'b1;
    cycle();
    chk("rst_mid_op", op, '0);
    chk("rst_mid_ra", ra, '0);
    clear_inputs();
    op_in = 11'd1; format_in = 3'd1; reg_write_in = 1'b1; ra_addr = 7'd40; rb_addr = 7'd10;
    cycle();
    chk("rst_after_ra", ra, '0);
    chk("rst_after_rb", rb, '0);
    chk("rst_after_op", op, 11'd1);

    // Random traffic over a small address window to force frequent matches.
    for (int n = 0; n < 400; n++) begin
      clear_inputs();
      if ($urandom_range(0, 7) == 0) begin
        op_in = '0; format_in = '0;
      end else begin
        op_in = 11'($urandom); format_in = 3'($urandom);
      end
      rt_addr_in = 7'($urandom); imm_in = 18'($urandom); reg_write_in = 1'($urandom);
      ra_addr = 7'($urandom_range(0, 15));
      rb_addr = 7'($urandom_range(0, 15));
      rc_addr = 7'($urandom_range(0, 15));
      for (int k = 0; k < D; k++) begin
        fwd_even_data[k*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
        fwd_even_addr[k*7 +: 7] = 7'($urandom_range(0, 15));
        fwd_even_valid[k] = ($urandom_range(0, 2) == 0);
        fwd_odd_data[k*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
        fwd_odd_addr[k*7 +: 7] = 7'($urandom_range(0, 15));
        fwd_odd_valid[k] = ($urandom_range(0, 2) == 0);
      end
      wb_even_we = 1'($urandom); wb_even_addr = 7'($urandom_range(0, 15));
      wb_even_data = {$urandom, $urandom, $urandom, $urandom};
      wb_odd_we = 1'($urandom); wb_odd_addr = 7'($urandom_range(0, 15));
      wb_odd_data = {$urandom, $urandom, $urandom, $urandom};
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
